// File: rtl/deser8.sv
// deser8: one-bit-per-cycle serial to 8-bit parallel deserializer.
// The serial side and the parallel side each use a valid/ready handshake.
// Finished words go into a one-entry holding register. When the consumer
// pops the held word in the same cycle that a new word completes, the new
// word loads directly, so the output never shows a bubble.
module deser8 #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] bit_count
);

    // Returns w with bit position pos replaced by b.
    function automatic logic [7:0] put_bit(input logic [7:0] w,
                                           input logic [2:0] pos,
                                           input logic       b);
        logic [7:0] r;
        r      = w;
        r[pos] = b;
        return r;
    endfunction

    // Stage p0 holds the partial word being assembled.
    logic [2:0] cnt_p0;
    logic [7:0] shift_p0;

    // Stage p1 is the holding register presented to the consumer.
    logic [7:0] data_p1;
    logic       vld_p1;

    logic       accept;
    logic       pop;
    logic       last_bit;
    logic       complete;
    logic [2:0] pos;
    logic [7:0] word_next;

    // Handshake decode and next-word assembly.
    always_comb begin
        // Stall only when the incoming bit would finish a word and the
        // holding register is still occupied and not being drained.
        in_ready  = !((cnt_p0 == 3'd7) && vld_p1 && !out_ready);
        accept    = in_valid && in_ready;
        pop       = vld_p1 && out_ready;
        last_bit  = (cnt_p0 == 3'd7);
        // clear discards the bit accepted in its cycle, so a flushed word
        // never reaches the holding register.
        complete  = accept && last_bit && !clear;
        pos       = MSB_FIRST ? (3'd7 - cnt_p0) : cnt_p0;
        word_next = put_bit(shift_p0, pos, in_bit);
    end

    // Partial-word shift register and bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p0   <= 3'd0;
            shift_p0 <= 8'h00;
        end else if (clear) begin
            cnt_p0   <= 3'd0;
            shift_p0 <= 8'h00;
        end else if (accept) begin
            if (last_bit) begin
                cnt_p0   <= 3'd0;
                shift_p0 <= 8'h00;
            end else begin
                cnt_p0   <= cnt_p0 + 3'd1;
                shift_p0 <= word_next;
            end
        end
    end

    // One-entry output holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_p1 <= 8'h00;
            vld_p1  <= 1'b0;
        end else if (complete) begin
            data_p1 <= word_next;
            vld_p1  <= 1'b1;
        end else if (pop) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_data  = data_p1;
    assign out_valid = vld_p1;
    assign bit_count = cnt_p0;

endmodule

// File: tb/tb_deser8.sv
// tb_deser8: scoreboard bench for deser8. Two instances (LSB-first and
// MSB-first) share all inputs. Every completed 8-bit group pushes its
// expected word for each instance into a queue. A monitor pops the queue
// and compares it with the DUT word whenever a word is consumed.
module tb_deser8;

    logic       clk = 1'b0;
    logic       reset, clear, in_bit, in_valid, out_ready;
    logic       in_ready0, in_ready1, out_valid0, out_valid1;
    logic [7:0] out_data0, out_data1;
    logic [2:0] bit_count0, bit_count1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    logic       mbits[$];
    int         pops[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    deser8 #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(reset), .clear(clear), .in_bit(in_bit),
        .in_valid(in_valid), .in_ready(in_ready0), .out_data(out_data0),
        .out_valid(out_valid0), .out_ready(out_ready), .bit_count(bit_count0)
    );

    deser8 #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .in_bit(in_bit),
        .in_valid(in_valid), .in_ready(in_ready1), .out_data(out_data1),
        .out_valid(out_valid1), .out_ready(out_ready), .bit_count(bit_count1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference model: collect accepted bits and build both expected words.
    task automatic model_push(input logic b);
        logic [7:0] w0, w1;
        mbits.push_back(b);
        if (mbits.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                w0[i]     = mbits[i];
                w1[7 - i] = mbits[i];
            end
            exp0.push_back(w0);
            exp1.push_back(w1);
            mbits.delete();
        end
    endtask

    // Monitor: compare each consumed word against the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_ready && (out_valid0 || out_valid1)) begin
            total++;
            if (exp0.size() == 0 || exp1.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got %0h/%0h expected none", out_data0, out_data1);
            end else begin
                logic [7:0] e0, e1;
                e0 = exp0.pop_front();
                e1 = exp1.pop_front();
                if (!out_valid0 || !out_valid1 || out_data0 !== e0 || out_data1 !== e1) begin
                    bad++;
                    $display("FAIL pop_word: got %0h/%0h v=%0b%0b expected %0h/%0h",
                             out_data0, out_data1, out_valid0, out_valid1, e0, e1);
                end
            end
            pops.push_back(cyc);
        end
    end

    // Drives one bit and waits (bounded) until it is accepted.
    task automatic send_bit(input logic b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_bit   = b;
        @(negedge clk);
        while (!in_ready0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready0) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        model_push(b);
    endtask

    task automatic send_byte(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp0.delete();
        exp1.delete();
        mbits.delete();
    endtask

    initial begin
        logic [7:0] bp;
        int n;
        reset = 1'b1; clear = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        chk("rst_out_data", {24'd0, out_data0}, 32'h00);
        chk("rst_bit_count", {29'd0, bit_count0}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready0}, 32'd1);

        // Word assembly in both bit orders
        send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        send_bit(0); send_bit(0); send_bit(1); send_bit(0);
        in_valid = 1'b0;
        chk("asm_out_valid", {31'd0, out_valid0}, 32'd1);
        chk("asm_lsb_data", {24'd0, out_data0}, 32'h4D);
        chk("asm_msb_data", {24'd0, out_data1}, 32'hB2);
        chk("asm_bit_count", {29'd0, bit_count0}, 32'd0);

        // Backpressure: 8'h96 queued behind the held 8'h4D
        bp = 8'h96;
        for (int i = 0; i < 7; i++) send_bit(bp[i]);
        chk("bp_bit_count", {29'd0, bit_count0}, 32'd7);
        in_valid = 1'b1;
        in_bit   = bp[7];
        repeat (2) begin
            @(negedge clk);
            chk("bp_in_ready_stall", {31'd0, in_ready0}, 32'd0);
            @(posedge clk);
            #1;
        end
        chk("bp_count_hold", {29'd0, bit_count0}, 32'd7);
        out_ready = 1'b1;
        send_bit(bp[7]);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("bp_out_valid", {31'd0, out_valid0}, 32'd1);
        chk("bp_lsb_data", {24'd0, out_data0}, 32'h96);
        chk("bp_msb_data", {24'd0, out_data1}, 32'h69);
        drain();
        chk("bp_drained", {31'd0, out_valid0}, 32'd0);

        // Back-to-back streaming with the consumer always ready
        pops.delete();
        out_ready = 1'b1;
        send_byte(8'hA5); send_byte(8'h3C); send_byte(8'hFF); send_byte(8'h00);
        idle(3);
        out_ready = 1'b0;
        chk("stream_pop_count", pops.size(), 32'd4);
        n = pops.size();
        for (int i = 1; i < n; i++)
            chk("stream_spacing", pops[i] - pops[i - 1], 32'd8);

        // clear mid-word while a word is held
        send_byte(8'h5A);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        chk("clr_pre_count", {29'd0, bit_count0}, 32'd5);
        clear = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0; in_valid = 1'b0;
        mbits.delete();
        chk("clr_bit_count", {29'd0, bit_count0}, 32'd0);
        chk("clr_hold_valid", {31'd0, out_valid0}, 32'd1);
        chk("clr_hold_data", {24'd0, out_data0}, 32'h5A);
        bp = 8'hC3;
        for (int i = 0; i < 7; i++) send_bit(bp[i]);
        out_ready = 1'b1;
        send_bit(bp[7]);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("clr_new_data", {24'd0, out_data0}, 32'hC3);
        drain();

        // Reset mid-operation with a held word and a partial word
        send_byte(8'h11);
        send_bit(1); send_bit(0); send_bit(1);
        in_valid = 1'b0;
        chk("rst2_pre_count", {29'd0, bit_count0}, 32'd3);
        chk("rst2_pre_valid", {31'd0, out_valid0}, 32'd1);
        do_reset();
        chk("rst2_out_valid", {31'd0, out_valid0}, 32'd0);
        chk("rst2_out_data", {24'd0, out_data0}, 32'h00);
        chk("rst2_bit_count", {29'd0, bit_count0}, 32'd0);
        chk("rst2_in_ready", {31'd0, in_ready0}, 32'd1);
        chk("rst2_msb_data", {24'd0, out_data1}, 32'h00);

        idle(2);
        chk("sb_empty", exp0.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
